// File: rtl/dma_arb_pkg.sv
// Shared state encoding and the modular priority search used by the DMA channel arbiter.
package dma_arb_pkg;

  localparam int MAX_CH = 16;

  typedef enum logic [3:0] {
    SIDLE  = 4'b0001,
    SREQ   = 4'b0010,
    SGRANT = 4'b0100,
    SREL   = 4'b1000
  } arb_state_t;

  // Returns {found, index}: first set bit of eff_req searching upward from ptr, wrapping at num_ch.
  function automatic logic [4:0] rot_priority_pick(input logic [MAX_CH-1:0] eff_req,
                                                   input logic [3:0]        ptr,
                                                   input logic [4:0]        num_ch);
    logic [4:0] pick;
    logic [4:0] idx;
    pick = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + 5'(i);
      if (idx >= num_ch) idx = idx - num_ch;
      if ((5'(i) < num_ch) && eff_req[idx[3:0]]) pick = {1'b1, idx[3:0]};
    end
    return pick;
  endfunction

endpackage

// File: rtl/dma_prio_encoder.sv
// Combinational request picker: lowest index in fixed mode, round-robin from ptr_i in rotating mode.
module dma_prio_encoder
  import dma_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  input  logic              rotate_i,
  output logic              found_o,
  output logic [CH_W-1:0]   idx_o
);

  logic [MAX_CH-1:0] req_pad;
  logic [3:0]        ptr_pad;
  logic [4:0]        pick;

  always_comb begin
    req_pad = '0;
    req_pad[NUM_CH-1:0] = req_i;
    ptr_pad = '0;
    if (rotate_i) ptr_pad[CH_W-1:0] = ptr_i;
    pick = rot_priority_pick(req_pad, ptr_pad, 5'(NUM_CH));
  end

  assign found_o = pick[4];
  assign idx_o   = CH_W'(pick[3:0]);

endmodule

// File: rtl/dma_channel_arbiter.sv
// N-channel DMA request arbiter with HRQ/HLDA handshake and one-hot DACK.
// Optional HLDA wait timeout with sticky error is enabled by DMA_ARB_HLDA_TIMEOUT_EN.
module dma_channel_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = $clog2(NUM_CH),
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic              dreqSense,
  input  logic              dackSense,
  input  logic              priorityType,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic [NUM_CH-1:0] swReqSet,
  input  logic              HLDA,
  input  logic              xferDone,
  input  logic              tcIn,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic              grantValid,
  output logic [CH_W-1:0]   grantCh,
  output logic [NUM_CH-1:0] swReqReg
`ifdef DMA_ARB_HLDA_TIMEOUT_EN
  ,output logic             hldaTimeoutErr
`endif
);

  arb_state_t        state_q;
  logic              hrq_q;
  logic              gv_q;
  logic [CH_W-1:0]   grant_ch_q;
  logic [CH_W-1:0]   ptr_q;
  logic [NUM_CH-1:0] dack_q;
  logic [NUM_CH-1:0] sw_req_q;
  logic [NUM_CH-1:0] sw_req_d;
  logic [NUM_CH-1:0] sw_clr;
  logic [NUM_CH-1:0] eff_req;
  logic [CH_W-1:0]   ptr_inc;
  logic              win_found;
  logic [CH_W-1:0]   win_ch;

  // Software requests bypass the mask so firmware can always start a channel.
  assign eff_req = ((DREQ ^ {NUM_CH{dreqSense}}) & ~maskReg) | sw_req_q;

  dma_prio_encoder #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_prio (
    .req_i    (eff_req),
    .ptr_i    (ptr_q),
    .rotate_i (priorityType),
    .found_o  (win_found),
    .idx_o    (win_ch)
  );

  always_comb begin
    sw_clr = '0;
    if ((state_q == SGRANT) && xferDone && tcIn) sw_clr[grant_ch_q] = 1'b1;
    sw_req_d = (sw_req_q & ~sw_clr) | swReqSet;
    ptr_inc  = (grant_ch_q == CH_W'(NUM_CH - 1)) ? '0 : grant_ch_q + 1'b1;
  end

`ifdef DMA_ARB_HLDA_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [TO_W-1:0] to_cnt_q;
  logic            to_err_q;
  logic            to_hit;

  assign to_hit         = (to_cnt_q == TO_W'(TIMEOUT_CYC));
  assign hldaTimeoutErr = to_err_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) to_cnt_q <= '0;
    else       to_cnt_q <= (state_q == SREQ) ? to_cnt_q + 1'b1 : '0;
  end
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= SIDLE;
      hrq_q      <= 1'b0;
      gv_q       <= 1'b0;
      grant_ch_q <= '0;
      ptr_q      <= '0;
      dack_q     <= '0;
      sw_req_q   <= '0;
`ifdef DMA_ARB_HLDA_TIMEOUT_EN
      to_err_q   <= 1'b0;
`endif
    end else begin
      sw_req_q <= sw_req_d;
      case (state_q)
        SIDLE: begin
          if (win_found) begin
            state_q <= SREQ;
            hrq_q   <= 1'b1;
          end
        end
        // Arbitration stays live here so a late higher-priority request still wins at HLDA.
        SREQ: begin
          if (!win_found) begin
            state_q <= SIDLE;
            hrq_q   <= 1'b0;
          end else if (HLDA) begin
            state_q    <= SGRANT;
            grant_ch_q <= win_ch;
            dack_q     <= NUM_CH'(1) << win_ch;
            gv_q       <= 1'b1;
          end
`ifdef DMA_ARB_HLDA_TIMEOUT_EN
          else if (to_hit) begin
            state_q  <= SREL;
            hrq_q    <= 1'b0;
            to_err_q <= 1'b1;
          end
`endif
        end
        SGRANT: begin
          if (xferDone) begin
            state_q <= SREL;
            hrq_q   <= 1'b0;
            gv_q    <= 1'b0;
            dack_q  <= '0;
            if (priorityType) ptr_q <= ptr_inc;
          end
        end
        SREL: begin
          state_q <= SIDLE;
        end
        default: begin
          state_q <= SIDLE;
          hrq_q   <= 1'b0;
          gv_q    <= 1'b0;
          dack_q  <= '0;
        end
      endcase
    end
  end

  assign HRQ        = hrq_q;
  assign grantValid = gv_q;
  assign grantCh    = grant_ch_q;
  assign swReqReg   = sw_req_q;
  assign DACK       = dack_q ^ {NUM_CH{dackSense}};

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Scoreboard bench for dma_channel_arbiter: directed scenarios followed by randomized transactions.
module tb_dma_channel_arbiter;

  localparam int N  = 4;
  localparam int CW = 2;
  localparam int TO = 255;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [N-1:0]  DREQ;
  logic          dreqSense;
  logic          dackSense;
  logic          priorityType;
  logic [N-1:0]  maskReg;
  logic [N-1:0]  swReqSet;
  logic          HLDA;
  logic          xferDone;
  logic          tcIn;
  logic          HRQ;
  logic [N-1:0]  DACK;
  logic          grantValid;
  logic [CW-1:0] grantCh;
  logic [N-1:0]  swReqReg;
`ifdef DMA_ARB_HLDA_TIMEOUT_EN
  logic          hldaTimeoutErr;
`endif

  dma_channel_arbiter #(.NUM_CH(N), .CH_W(CW), .TIMEOUT_CYC(TO)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .DREQ         (DREQ),
    .dreqSense    (dreqSense),
    .dackSense    (dackSense),
    .priorityType (priorityType),
    .maskReg      (maskReg),
    .swReqSet     (swReqSet),
    .HLDA         (HLDA),
    .xferDone     (xferDone),
    .tcIn         (tcIn),
    .HRQ          (HRQ),
    .DACK         (DACK),
    .grantValid   (grantValid),
    .grantCh      (grantCh),
    .swReqReg     (swReqReg)
`ifdef DMA_ARB_HLDA_TIMEOUT_EN
    ,.hldaTimeoutErr (hldaTimeoutErr)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int           ch;
    logic [N-1:0] dack;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         cur;
  logic         gv_prev = 1'b0;
  logic [N-1:0] m_sw;
  int           m_ptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference rules: active requests after polarity and mask, plus software requests.
  function automatic logic [N-1:0] eff_of(input logic [N-1:0] dreq, input logic [N-1:0] mask,
                                          input logic ds, input logic [N-1:0] sw);
    logic [N-1:0] act;
    for (int k = 0; k < N; k++) act[k] = ds ? ~dreq[k] : dreq[k];
    return (act & ~mask) | sw;
  endfunction

  function automatic int winner(input logic [N-1:0] eff, input int start);
    for (int k = 0; k < N; k++) begin
      if (eff[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  // Monitor: pops an expectation on each new grant and checks the grant stays frozen.
  always @(negedge CLK) begin
    if (RESET) begin
      gv_prev = 1'b0;
    end else begin
      if (grantValid && !gv_prev) begin
        if (exp_q.size() == 0) begin
          chk("grant_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          cur = exp_q.pop_front();
          chk("grant_ch", 32'(grantCh), 32'(cur.ch));
          chk("grant_dack", 32'(DACK), 32'(cur.dack));
        end
      end else if (grantValid) begin
        chk("hold_ch", 32'(grantCh), 32'(cur.ch));
        chk("hold_dack", 32'(DACK), 32'(cur.dack));
      end
      gv_prev = grantValid;
    end
  end

  task automatic do_xact(input logic [N-1:0] dreq1, input logic [N-1:0] dreq2,
                         input logic [N-1:0] mask, input logic [N-1:0] swset,
                         input logic ds, input logic ks, input logic prio, input logic tc,
                         input logic [N-1:0] sw_late, input int hold);
    logic [N-1:0] eff;
    int           w;
    int           waited;
    exp_t         e;
    @(negedge CLK);
    dreqSense = ds; dackSense = ks; priorityType = prio; maskReg = mask;
    DREQ = dreq1; swReqSet = swset; HLDA = 1'b0;
    xferDone = 1'b1; tcIn = 1'b1;
    @(negedge CLK);
    swReqSet = '0; xferDone = 1'b0; tcIn = 1'b0;
    m_sw |= swset;
    eff = eff_of(dreq1, mask, ds, m_sw);
    repeat (2) @(negedge CLK);
    chk("hrq_req", 32'(HRQ), 32'(eff != '0));
    DREQ = dreq2;
    eff = eff_of(dreq2, mask, ds, m_sw);
    repeat (3) @(negedge CLK);
    chk("hrq_live", 32'(HRQ), 32'(eff != '0));
    if (eff == '0) begin
      chk("no_grant", 32'(grantValid), 32'd0);
      return;
    end
    w = winner(eff, prio ? m_ptr : 0);
    e.ch = w;
    e.dack = (N'(1) << w) ^ {N{ks}};
    exp_q.push_back(e);
    HLDA = 1'b1;
    waited = 0;
    while (!grantValid && waited < 10) begin
      @(negedge CLK);
      waited++;
    end
    chk("grant_seen", 32'(grantValid), 32'd1);
    if (!grantValid) begin
      exp_q.delete();
      HLDA = 1'b0;
      return;
    end
    repeat (hold) begin
      @(negedge CLK);
      DREQ = N'($urandom); maskReg = N'($urandom); HLDA = 1'($urandom);
    end
    xferDone = 1'b1; tcIn = tc; swReqSet = sw_late;
    @(negedge CLK);
    xferDone = 1'b0; tcIn = 1'b0; swReqSet = '0; HLDA = 1'b0;
    if (tc) m_sw[w] = 1'b0;
    m_sw |= sw_late;
    if (prio) m_ptr = (w + 1) % N;
    chk("rel_hrq", 32'(HRQ), 32'd0);
    chk("rel_gv", 32'(grantValid), 32'd0);
    chk("rel_dack", 32'(DACK), 32'({N{ks}}));
    chk("sw_reg", 32'(swReqReg), 32'(m_sw));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int           w;
    int           waited;
    exp_t         e;
    RESET = 1'b1; DREQ = '0; dreqSense = 1'b0; dackSense = 1'b1; priorityType = 1'b0;
    maskReg = '0; swReqSet = '0; HLDA = 1'b0; xferDone = 1'b0; tcIn = 1'b0;
    m_sw = '0; m_ptr = 0;
    #12;
    chk("rst_hrq", 32'(HRQ), 32'd0);
    chk("rst_gv", 32'(grantValid), 32'd0);
    chk("rst_ch", 32'(grantCh), 32'd0);
    chk("rst_sw", 32'(swReqReg), 32'd0);
    chk("rst_dack_low", 32'(DACK), 32'hF);
    @(negedge CLK);
    dackSense = 1'b0;
    RESET = 1'b0;

    // Fixed priority picks ch1 out of 0110, then ch2 alone.
    do_xact(4'b0110, 4'b0110, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2);
    do_xact(4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2);
    // Rotating order 0,1,2,3,0 with all requests held.
    for (int i = 0; i < 5; i++)
      do_xact(4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 3);
    // Masked hardware request, then software request overriding the mask, cleared by TC.
    do_xact(4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1);
    do_xact(4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1);
    // Active-low DREQ and DACK.
    do_xact(4'b1011, 4'b1011, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 2);
    // Late higher-priority request before HLDA, then withdrawal before HLDA.
    do_xact(4'b0100, 4'b0101, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1);
    do_xact(4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1);
    // Software set colliding with TC clear of the same channel: set must win.
    do_xact(4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 1);
    do_xact(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1);

    for (int i = 0; i < 40; i++)
      do_xact(N'($urandom), N'($urandom),
              ($urandom % 3 == 0) ? N'($urandom) : N'(0),
              ($urandom % 4 == 0) ? N'($urandom) : N'(0),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              ($urandom % 6 == 0) ? N'($urandom) : N'(0),
              1 + int'($urandom % 4));

`ifdef DMA_ARB_HLDA_TIMEOUT_EN
    @(negedge CLK);
    dreqSense = 1'b0; maskReg = '0; DREQ = 4'b0001; HLDA = 1'b0;
    chk("to_err_clear", 32'(hldaTimeoutErr), 32'd0);
    waited = 0;
    while (!HRQ && waited < 5) begin
      @(negedge CLK);
      waited++;
    end
    chk("to_hrq_up", 32'(HRQ), 32'd1);
    waited = 0;
    while (HRQ && waited < TO + 20) begin
      @(negedge CLK);
      waited++;
    end
    chk("to_hrq_drop", 32'(HRQ), 32'd0);
    chk("to_len", 32'(waited >= TO), 32'd1);
    chk("to_err_set", 32'(hldaTimeoutErr), 32'd1);
`endif

    // Asynchronous reset in the middle of a grant.
    @(negedge CLK);
    dreqSense = 1'b0; dackSense = 1'b0; priorityType = 1'b0; maskReg = '0;
    DREQ = 4'b0001; HLDA = 1'b0;
    repeat (3) @(negedge CLK);
    w = winner(eff_of(DREQ, maskReg, 1'b0, m_sw), 0);
    e.ch = w;
    e.dack = N'(1) << w;
    exp_q.push_back(e);
    HLDA = 1'b1;
    waited = 0;
    while (!grantValid && waited < 10) begin
      @(negedge CLK);
      waited++;
    end
    chk("rst_pre_grant", 32'(grantValid), 32'd1);
    @(posedge CLK);
    #3;
    RESET = 1'b1;
    #1;
    m_sw = '0; m_ptr = 0;
    chk("arst_hrq", 32'(HRQ), 32'd0);
    chk("arst_gv", 32'(grantValid), 32'd0);
    chk("arst_dack", 32'(DACK), 32'd0);
    chk("arst_sw", 32'(swReqReg), 32'(m_sw));
`ifdef DMA_ARB_HLDA_TIMEOUT_EN
    chk("arst_err", 32'(hldaTimeoutErr), 32'd0);
`endif
    @(negedge CLK);
    RESET = 1'b0; HLDA = 1'b0; DREQ = '0;
    exp_q.delete();
    repeat (3) @(negedge CLK);
    chk("post_rst_hrq", 32'(HRQ), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
